// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Step counter must hold values 0..WIDTH.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: brings in the next dividend bit and trial-subtracts the divisor.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   next_rem,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH+1:0] dvs_ext;

  always_comb begin
    shifted  = {rem, dvd_bit};
    dvs_ext  = {2'b00, dvs};
    diff     = shifted - dvs_ext;
    q_bit    = (shifted >= dvs_ext);
    next_rem = q_bit ? (WIDTH+1)'(diff) : (WIDTH+1)'(shifted);
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per clock, with start/ready/done handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             error,
  output logic             ovf,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] x_save;
  logic [WIDTH:0]   rem;
  logic             neg_q;
  logic             neg_r;
  logic             err_pend;
  logic             ovf_pend;

  logic [WIDTH:0]   step_rem;
  logic             step_q;

  logic             x_neg_c;
  logic             y_neg_c;
  logic [WIDTH-1:0] x_mag_c;
  logic [WIDTH-1:0] y_mag_c;
  logic             ovf_c;
  logic [WIDTH-1:0] rem_lo_c;
  logic [WIDTH-1:0] q_fix_c;
  logic [WIDTH-1:0] r_fix_c;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_bit  (dvd[WIDTH-1]),
    .dvs      (dvs),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  // Operand magnitudes at accept time and sign fix-up of the finished result.
  always_comb begin
    x_neg_c  = signed_op & x[WIDTH-1];
    y_neg_c  = signed_op & y[WIDTH-1];
    x_mag_c  = x_neg_c ? (~x + WIDTH'(1)) : x;
    y_mag_c  = y_neg_c ? (~y + WIDTH'(1)) : y;
    ovf_c    = signed_op & (x == MIN_VAL) & (y == {WIDTH{1'b1}});
    rem_lo_c = WIDTH'(rem);
    q_fix_c  = neg_q ? (~dvd + WIDTH'(1)) : dvd;
    r_fix_c  = neg_r ? (~rem_lo_c + WIDTH'(1)) : rem_lo_c;
  end

  // Control FSM and datapath registers; the dividend register fills with quotient bits from the LSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      x_save   <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      err_pend <= 1'b0;
      ovf_pend <= 1'b0;
      ready    <= 1'b1;
      q        <= '0;
      r        <= '0;
      error    <= 1'b0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ready    <= 1'b0;
            neg_q    <= x_neg_c ^ y_neg_c;
            neg_r    <= x_neg_c;
            dvd      <= x_mag_c;
            dvs      <= y_mag_c;
            x_save   <= x;
            rem      <= '0;
            cnt      <= '0;
            ovf_pend <= ovf_c;
            if (y == '0) begin
              err_pend <= 1'b1;
              state    <= FIX;
            end else begin
              err_pend <= 1'b0;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          rem <= step_rem;
          dvd <= {dvd[WIDTH-2:0], step_q};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (err_pend) begin
            q     <= {WIDTH{1'b1}};
            r     <= x_save;
            error <= 1'b1;
            ovf   <= 1'b0;
          end else begin
            q     <= q_fix_c;
            r     <= r_fix_c;
            error <= 1'b0;
            ovf   <= ovf_pend;
          end
          done  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, handshake corners, mid-op reset and random operations.
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         ready;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         error;
  logic         ovf;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .x         (x),
    .y         (y),
    .ready     (ready),
    .q         (q),
    .r         (r),
    .error     (error),
    .ovf       (ovf),
    .done      (done)
  );

  // Reference: plain integer division (truncates toward zero, remainder follows dividend).
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                  output logic [W-1:0] eq, output logic [W-1:0] er,
                                  output bit ee, output bit eo);
    int ia, ib, qi, ri;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    ee = 1'b0;
    eo = 1'b0;
    if (ib == 0) begin
      eq = '1;
      er = a;
      ee = 1'b1;
    end else if (s && ia == -(2 ** (W - 1)) && ib == -1) begin
      eq = a;
      er = '0;
      eo = 1'b1;
    end else begin
      qi = ia / ib;
      ri = ia % ib;
      eq = W'(qi);
      er = W'(ri);
    end
  endfunction

  // Issue one operation from a sampling point (#1 after an edge) and check latency and results.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input string tag, input bit check_tail);
    logic [W-1:0] eq, er;
    bit ee, eo;
    int n, lat;
    ref_div(a, b, s, eq, er, ee, eo);
    lat = (b == '0) ? 1 : W + 1;
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_before_start got %b want 1", tag, ready);
    end
    signed_op = s;
    x = a;
    y = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x = W'($urandom);
    y = W'($urandom);
    signed_op = 1'($urandom_range(0, 1));
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s ready_drop got %b want 0", tag, ready);
    end
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done !== 1'b1 && n < 30);
    vectors++;
    if (n != lat) begin
      miscompares++;
      $display("FAIL %s latency got %0d want %0d", tag, n, lat);
    end
    vectors++;
    if ({q, r, error, ovf} !== {eq, er, ee, eo}) begin
      miscompares++;
      $display("FAIL %s result a=%h b=%h s=%0d got q=%h r=%h err=%b ovf=%b want q=%h r=%h err=%b ovf=%b",
               tag, a, b, s, q, r, error, ovf, eq, er, ee, eo);
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_with_done got %b want 1", tag, ready);
    end
    if (check_tail) begin
      @(posedge clk);
      #1;
      vectors++;
      if (done !== 1'b0 || {q, r, error, ovf} !== {eq, er, ee, eo}) begin
        miscompares++;
        $display("FAIL %s done_pulse_hold got done=%b q=%h r=%h want done=0 q=%h r=%h", tag, done, q, r, eq, er);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    signed_op = 1'b0;
    x = '0;
    y = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({q, r, error, ovf, done, ready} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_values got q=%h r=%h err=%b ovf=%b done=%b ready=%b want 0,0,0,0,0,1",
               q, r, error, ovf, done, ready);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({done, ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_release got done=%b ready=%b want 0 1", done, ready);
    end
  endtask

  task automatic test_directed();
    run_op(8'd200, 8'd7, 1'b0, "unsigned_200_7", 1'b1);
    run_op(8'hF9, 8'd2, 1'b1, "signed_m7_2", 1'b1);
    run_op(8'd7, 8'hFE, 1'b1, "signed_7_m2", 1'b1);
    run_op(8'd13, 8'd0, 1'b0, "div_zero", 1'b1);
    run_op(8'd100, 8'd10, 1'b0, "error_clear", 1'b1);
    run_op(8'h80, 8'hFF, 1'b1, "signed_ovf", 1'b1);
    run_op(8'hFF, 8'hFF, 1'b0, "unsigned_max", 1'b1);
    run_op(8'h80, 8'h01, 1'b1, "signed_min_1", 1'b1);
  endtask

  task automatic test_ignore_start();
    int n, dones;
    signed_op = 1'b0;
    x = 8'd99;
    y = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    x = 8'd3;
    y = 8'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 4;
    while (done !== 1'b1 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (n != W + 1) begin
      miscompares++;
      $display("FAIL ignore_start_latency got %0d want %0d", n, W + 1);
    end
    vectors++;
    if ({q, r, error} !== {8'd19, 8'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL ignore_start_result got q=%h r=%h err=%b want q=13 r=04 err=0", q, r, error);
    end
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL ignore_start_extra_done got %0d want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    run_op(8'd250, 8'd3, 1'b0, "b2b_first", 1'b0);
    run_op(8'h9C, 8'd9, 1'b1, "b2b_second", 1'b0);
    run_op(8'd40, 8'd0, 1'b0, "b2b_zero", 1'b0);
    run_op(8'd41, 8'd6, 1'b0, "b2b_fourth", 1'b1);
  endtask

  task automatic test_reset_mid();
    int dones;
    run_op(8'd200, 8'd7, 1'b0, "pre_reset", 1'b1);
    signed_op = 1'b0;
    x = 8'd77;
    y = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if ({q, r, error, ovf, done, ready} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_reset_async got q=%h r=%h err=%b ovf=%b done=%b ready=%b want 0,0,0,0,0,1",
               q, r, error, ovf, done, ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    dones = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL mid_reset_no_done got %0d want 0", dones);
    end
    run_op(8'd77, 8'd5, 1'b0, "post_reset", 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    bit s;
    for (int i = 0; i < 150; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin
          s = 1'b1;
          a = 8'h80;
          b = 8'hFF;
        end
        2: b = W'($urandom_range(1, 3));
        default: ;
      endcase
      run_op(a, b, s, "random", 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
